// File: rtl/fwd_scoreboard.sv
// Hazard scoreboard: tracks destination/Tnew of in-flight instructions and
// derives D-stage stall plus D/E forwarding selects from the tracked state.
module fwd_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int AW     = 5,
  parameter int TW     = 2,
  parameter int SW     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_wa,
  input  logic [TW-1:0] d_tnew,
  input  logic          flush,
  output logic          stall,
  output logic          d_rs_hit,
  output logic [SW-1:0] d_rs_sel,
  output logic          d_rt_hit,
  output logic [SW-1:0] d_rt_sel,
  output logic          e_rs_hit,
  output logic [SW-1:0] e_rs_sel,
  output logic          e_rt_hit,
  output logic [SW-1:0] e_rt_sel
);

  logic          vld_reg [1:NSTAGE];
  logic [AW-1:0] wa_reg  [1:NSTAGE];
  logic [TW-1:0] tn_reg  [1:NSTAGE];
  logic          e_vld_reg;
  logic [AW-1:0] e_rs_reg;
  logic [AW-1:0] e_rt_reg;

  // Lookup slots: 0 = D rs, 1 = D rt, 2 = E rs, 3 = E rt.
  logic [AW-1:0] op_addr  [4];
  logic          op_en    [4];
  logic          op_found [4];
  logic [SW-1:0] op_stage [4];
  logic [TW-1:0] op_tn    [4];

  assign op_addr[0] = d_rs;
  assign op_addr[1] = d_rt;
  assign op_addr[2] = e_rs_reg;
  assign op_addr[3] = e_rt_reg;
  assign op_en[0]   = d_valid;
  assign op_en[1]   = d_valid;
  assign op_en[2]   = e_vld_reg;
  assign op_en[3]   = e_vld_reg;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  // E consumers skip stage 1 since that entry is the E instruction's own result.
  always_comb begin
    for (int o = 0; o < 4; o++) begin
      op_found[o] = 1'b0;
      op_stage[o] = '0;
      op_tn[o]    = '0;
      for (int k = NSTAGE; k >= 1; k--) begin
        if ((o < 2 || k >= 2) && op_en[o] && (op_addr[o] != '0) &&
            vld_reg[k] && (wa_reg[k] == op_addr[o])) begin
          op_found[o] = 1'b1;
          op_stage[o] = SW'(k);
          op_tn[o]    = tn_reg[k];
        end
      end
    end
  end

  always_comb begin
    stall    = (op_found[0] && (op_tn[0] > d_tuse_rs)) ||
               (op_found[1] && (op_tn[1] > d_tuse_rt));
    d_rs_hit = op_found[0] && (op_tn[0] == '0);
    d_rt_hit = op_found[1] && (op_tn[1] == '0);
    e_rs_hit = op_found[2] && (op_tn[2] == '0);
    e_rt_hit = op_found[3] && (op_tn[3] == '0);
    d_rs_sel = d_rs_hit ? op_stage[0] : '0;
    d_rt_sel = d_rt_hit ? op_stage[1] : '0;
    e_rs_sel = e_rs_hit ? op_stage[2] : '0;
    e_rt_sel = e_rt_hit ? op_stage[3] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        vld_reg[k] <= 1'b0;
        wa_reg[k]  <= '0;
        tn_reg[k]  <= '0;
      end
      e_vld_reg <= 1'b0;
      e_rs_reg  <= '0;
      e_rt_reg  <= '0;
    end else begin
      for (int k = NSTAGE; k >= 2; k--) begin
        vld_reg[k] <= vld_reg[k-1] & ~flush;
        wa_reg[k]  <= wa_reg[k-1];
        tn_reg[k]  <= (tn_reg[k-1] == '0) ? '0 : tn_reg[k-1] - TW'(1);
      end
      if (flush || stall) begin
        vld_reg[1] <= 1'b0;
        wa_reg[1]  <= '0;
        tn_reg[1]  <= '0;
        e_vld_reg  <= 1'b0;
        e_rs_reg   <= '0;
        e_rt_reg   <= '0;
      end else begin
        vld_reg[1] <= d_valid && (d_wa != '0);
        wa_reg[1]  <= d_wa;
        tn_reg[1]  <= d_tnew;
        e_vld_reg  <= d_valid;
        e_rs_reg   <= d_rs;
        e_rt_reg   <= d_rt;
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard (NSTAGE=3): hazard scenarios with
// hand-computed stall/forward expectations.
module tb_fwd_scoreboard;

  logic       clk = 1'b0;
  logic       reset, d_valid, flush;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, d_rs_hit, d_rt_hit, e_rs_hit, e_rt_hit;
  logic [2:0] d_rs_sel, d_rt_sel, e_rs_sel, e_rt_sel;

  int vecs = 0;
  int errs = 0;

  fwd_scoreboard #(.NSTAGE(3), .AW(5), .TW(2), .SW(3)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wa(d_wa), .d_tnew(d_tnew),
    .flush(flush), .stall(stall),
    .d_rs_hit(d_rs_hit), .d_rs_sel(d_rs_sel), .d_rt_hit(d_rt_hit), .d_rt_sel(d_rt_sel),
    .e_rs_hit(e_rs_hit), .e_rs_sel(e_rs_sel), .e_rt_hit(e_rt_hit), .e_rt_sel(e_rt_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge, checks 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_wa = 0; d_tnew = 0;
    d_tuse_rs = 0; d_tuse_rt = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] wa, input logic [1:0] tn);
    idle();
    d_valid = 1; d_wa = wa; d_tnew = tn;
    tick();
  endtask

  task automatic read_d(input logic [4:0] rs, input logic [1:0] urs,
                        input logic [4:0] rt, input logic [1:0] urt);
    idle();
    d_valid = 1; d_rs = rs; d_tuse_rs = urs; d_rt = rt; d_tuse_rt = urt;
    #2;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_hits"}, {d_rs_hit, d_rt_hit, e_rs_hit, e_rt_hit}, 0);
    chk({tag, "_sels"}, {d_rs_sel, d_rt_sel, e_rs_sel, e_rt_sel}, 0);
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    #2;
    chk_quiet("reset");

    // Load-use: two stall cycles, then forward from stage 3
    issue(5'd2, 2'd2);
    read_d(5'd2, 2'd0, 5'd0, 2'd0);
    chk("lu_stall0", stall, 1);
    tick(); #2;
    chk("lu_stall1", stall, 1);
    tick(); #2;
    chk("lu_stall2", stall, 0);
    chk("lu_d_rs_hit", d_rs_hit, 1);
    chk("lu_d_rs_sel", d_rs_sel, 3);
    drain();

    // ALU-to-ALU: no stall at D, forward from stage 2 in E
    issue(5'd3, 2'd1);
    read_d(5'd3, 2'd1, 5'd0, 2'd0);
    chk("alu_stall", stall, 0);
    chk("alu_d_rs_hit", d_rs_hit, 0);
    tick(); idle(); #2;
    chk("alu_e_rs_hit", e_rs_hit, 1);
    chk("alu_e_rs_sel", e_rs_sel, 2);
    drain();

    // Youngest match wins, both at D and E
    issue(5'd4, 2'd0);
    issue(5'd4, 2'd0);
    read_d(5'd0, 2'd0, 5'd4, 2'd0);
    chk("yw_stall", stall, 0);
    chk("yw_d_rt_hit", d_rt_hit, 1);
    chk("yw_d_rt_sel", d_rt_sel, 1);
    tick(); idle(); #2;
    chk("yw_e_rt_hit", e_rt_hit, 1);
    chk("yw_e_rt_sel", e_rt_sel, 2);
    drain();

    // Zero register never stalls or forwards
    issue(5'd0, 2'd2);
    read_d(5'd0, 2'd0, 5'd0, 2'd0);
    chk_quiet("zero_d");
    tick(); idle(); #2;
    chk_quiet("zero_e");
    drain();

    // Tnew equal to Tuse: no stall, no D forward, no E forward yet
    issue(5'd5, 2'd2);
    read_d(5'd5, 2'd2, 5'd0, 2'd0);
    chk_quiet("teq_d");
    tick(); idle(); #2;
    chk("teq_e_rs_hit", e_rs_hit, 0);
    drain();

    // rt stalls one cycle, then E forwards from the last stage
    issue(5'd6, 2'd2);
    read_d(5'd0, 2'd0, 5'd6, 2'd1);
    chk("rt_stall0", stall, 1);
    tick(); #2;
    chk("rt_stall1", stall, 0);
    chk("rt_d_rt_hit", d_rt_hit, 0);
    tick(); idle(); #2;
    chk("rt_e_rt_hit", e_rt_hit, 1);
    chk("rt_e_rt_sel", e_rt_sel, 3);
    drain();

    // Flush during a load-use stall clears the dependency
    issue(5'd2, 2'd2);
    read_d(5'd2, 2'd0, 5'd0, 2'd0);
    chk("fl_stall0", stall, 1);
    flush = 1;
    tick();
    flush = 0; #2;
    chk("fl_stall1", stall, 0);
    chk("fl_d_rs_hit", d_rs_hit, 0);
    tick(); #2;
    chk("fl_stall2", stall, 0);
    chk("fl_d_rs_hit2", d_rs_hit, 0);
    drain();

    // Reset with three entries in flight, then normal ALU-to-ALU
    issue(5'd7, 2'd2);
    issue(5'd8, 2'd0);
    issue(5'd9, 2'd0);
    idle();
    reset = 1;
    tick();
    reset = 0;
    read_d(5'd9, 2'd0, 5'd8, 2'd0);
    chk_quiet("rst_d");
    read_d(5'd7, 2'd0, 5'd0, 2'd0);
    chk("rst_stall7", stall, 0);
    issue(5'd3, 2'd1);
    read_d(5'd3, 2'd1, 5'd0, 2'd0);
    chk("rst_alu_stall", stall, 0);
    chk("rst_alu_d_hit", d_rs_hit, 0);
    tick(); idle(); #2;
    chk("rst_alu_e_hit", e_rs_hit, 1);
    chk("rst_alu_e_sel", e_rs_sel, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
